// File: rtl/riego_multizona.sv
// riego_multizona: multi-zone irrigation controller.
// One shared light sensor, one humidity sensor and one electrovalve per zone.
// Requests are latched per zone. Valves open one at a time, chosen by a
// round-robin pointer, and are followed by a mandatory all-closed gap.
module riego_multizona #(
    parameter int ZONES       = 4,
    parameter int OPEN_CYCLES = 750_000_000,
    parameter int CNT_W       = 31,
    parameter int GAP_CYCLES  = 50_000_000,
    parameter int DEB_CYCLES  = 500_000,
    parameter int DEB_W       = 20
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             SL,
    input  logic [ZONES-1:0] SH,
    input  logic [ZONES-1:0] manual,
    output logic [ZONES-1:0] EV,
    output logic [5:0]       message,
    output logic [ZONES:0]   LED,
    output logic             busy
);

    localparam int PTR_W = (ZONES > 1) ? $clog2(ZONES) : 1;
    localparam int NB    = ZONES + 1;

    typedef enum logic [1:0] {IDLE, OPEN, GAP} state_t;

    // Bit ZONES carries the light sensor; bits ZONES-1..0 carry the humidity sensors.
    logic [NB-1:0]    sync1;
    logic [NB-1:0]    sync2;
    logic [NB-1:0]    deb;
    logic [NB-1:0]    deb_update;
    logic [DEB_W-1:0] deb_cnt [NB];
    logic [ZONES-1:0] sh_fall;

    logic             sl_deb;
    logic [ZONES-1:0] sh_deb;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [PTR_W-1:0] rr_ptr;
    logic [ZONES-1:0] pending;

    logic             grant_found;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] next_ptr;
    logic [ZONES-1:0] grant_onehot;
    logic [PTR_W-1:0] scan_idx;
    logic [ZONES-1:0] req;

    assign sl_deb = deb[ZONES];
    assign sh_deb = deb[ZONES-1:0];
    assign LED    = {~sl_deb, ~EV};
    assign req    = (sh_deb & {ZONES{~sl_deb}}) | manual;

    // Two-flop synchronizer for the asynchronous sensor pins.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {SL, SH};
            sync2 <= sync1;
        end
    end

    // A debounced bit flips once the synchronized value has disagreed for DEB_CYCLES cycles in a row.
    always_comb begin
        deb_update = '0;
        for (int b = 0; b < NB; b++) begin
            deb_update[b] = (sync2[b] != deb[b]) && (deb_cnt[b] == DEB_W'(DEB_CYCLES - 1));
        end
    end

    // Debounce counters, debounced values and a one-cycle falling-edge flag per humidity sensor.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            deb     <= '0;
            sh_fall <= '0;
            for (int b = 0; b < NB; b++) begin
                deb_cnt[b] <= '0;
            end
        end else begin
            sh_fall <= deb_update[ZONES-1:0] & deb[ZONES-1:0] & ~sync2[ZONES-1:0];
            for (int b = 0; b < NB; b++) begin
                if (deb_update[b]) begin
                    deb[b]     <= sync2[b];
                    deb_cnt[b] <= '0;
                end else if (sync2[b] != deb[b]) begin
                    deb_cnt[b] <= deb_cnt[b] + DEB_W'(1);
                end else begin
                    deb_cnt[b] <= '0;
                end
            end
        end
    end

    // Round-robin scan: first pending zone at or after rr_ptr, wrapping upward.
    always_comb begin
        grant_found  = 1'b0;
        grant_idx    = '0;
        grant_onehot = '0;
        scan_idx     = rr_ptr;
        for (int i = 0; i < ZONES; i++) begin
            if (!grant_found && pending[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
            scan_idx = (scan_idx == PTR_W'(ZONES - 1)) ? '0 : scan_idx + PTR_W'(1);
        end
        if (grant_found) begin
            grant_onehot[grant_idx] = 1'b1;
        end
        next_ptr = (grant_idx == PTR_W'(ZONES - 1)) ? '0 : grant_idx + PTR_W'(1);
    end

    // Request latch: the open zone cannot re-request, and a grant clears its own bit.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            pending <= (pending | (req & ~EV)) & ~((state == IDLE) ? grant_onehot : '0);
        end
    end

    // Watering sequencer with registered valve, message and busy outputs.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            rr_ptr  <= '0;
            EV      <= '0;
            message <= '0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (grant_found) begin
                        state   <= OPEN;
                        EV      <= grant_onehot;
                        rr_ptr  <= next_ptr;
                        message <= 6'd16 | 6'(grant_idx);
                        busy    <= 1'b1;
                    end else begin
                        message <= {5'd0, sl_deb};
                        busy    <= 1'b0;
                    end
                end
                OPEN: begin
                    if (((sh_fall & EV) != '0) || (cnt == CNT_W'(OPEN_CYCLES - 1))) begin
                        state   <= GAP;
                        EV      <= '0;
                        cnt     <= '0;
                        message <= 6'd2;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        message <= {5'd0, sl_deb};
                        busy    <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    EV      <= '0;
                    message <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
